expression_sequencer: RTL and testbench

Parametrised expression selector between the per-expression pixel sources and `spi_lcd`. It routes one of `N_EXPR` 16-bit pixel streams to the LCD data input. Changes come from a `go` edge, a direct-select handshake, or an auto-cycle timer, and every change is applied only on an LCD frame boundary so a frame is never torn.

---
 rtl/expression_sequencer_pkg.sv | 24 ++
 rtl/expression_sequencer_if.sv | 20 ++
 rtl/expression_sequencer_frame_tick_gen.sv | 23 ++
 rtl/expression_sequencer.sv | 151 +++++++++++++++
 tb/tb_expression_sequencer.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/expression_sequencer_pkg.sv
// expr_pkg: shared types for the expression sequencer.
// Holds expression IDs, selection FSM encoding and the default blank colour.
package expr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HAPPY   = 3'd1,
    SATISFY = 3'd2,
    SLEEP   = 3'd3,
    EXPECT  = 3'd4
  } expr_id_t;

  typedef enum logic [1:0] {
    ST_SHOW = 2'd0,
    ST_PEND = 2'd1
`ifdef EXPR_BLANK_EN
    ,
    ST_BLANK = 2'd2
`endif
  } sel_state_t;

  localparam logic [15:0] BLANK_COLOR_DEF = 16'h0000;

endpackage

// File: rtl/expression_sequencer_if.sv
// expression_sequencer_if: direct-select request channel.
// master: sel_valid/sel_id out, sel_ready/sel_err in; slave is the mirror.
interface expression_sequencer_if #(
  parameter int ID_W = 3
);
  logic            sel_valid;
  logic [ID_W-1:0] sel_id;
  logic            sel_ready;
  logic            sel_err;

  modport master (
    output sel_valid, sel_id,
    input  sel_ready, sel_err
  );

  modport slave (
    input  sel_valid, sel_id,
    output sel_ready, sel_err
  );
endinterface

// File: rtl/expression_sequencer_frame_tick_gen.sv
// frame_tick_gen: one-cycle tick when the LCD address first reaches (0,0).
// Ports: clk, rst_n, pix_addr_x/y in; tick out (combinational).
module frame_tick_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pix_addr_x,
  input  logic [ADDR_W-1:0] pix_addr_y,
  output logic              tick
);
  logic org;
  logic org_q;

  assign org  = (pix_addr_x == '0) && (pix_addr_y == '0);
  assign tick = org & ~org_q;

  // org_q resets high so an address parked at (0,0) gives no tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) org_q <= 1'b1;
    else        org_q <= org;
  end
endmodule

// File: rtl/expression_sequencer.sv
// expression_sequencer: frame-aligned mux of N_EXPR pixel sources to spi_lcd.
// Ports: clk, rst_n, go, auto_en, sel (select channel), pix_addr_x/y,
// src_data in; pix_data, cur_expr, busy, switch_pulse out.
// Build option: EXPR_BLANK_EN inserts one BLANK_COLOR frame per switch.
module expression_sequencer
  import expr_pkg::*;
#(
  parameter int              N_EXPR       = 5,
  parameter int              PIX_W        = 16,
  parameter int              ADDR_W       = 8,
  parameter int              DWELL_FRAMES = 60,
  parameter int              INIT_EXPR    = 0,
  parameter logic [PIX_W-1:0] BLANK_COLOR = BLANK_COLOR_DEF,
  localparam int             ID_W = (N_EXPR > 2) ? $clog2(N_EXPR) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    go,
  input  logic                    auto_en,
  expression_sequencer_if.slave   sel,
  input  logic [ADDR_W-1:0]       pix_addr_x,
  input  logic [ADDR_W-1:0]       pix_addr_y,
  input  logic [N_EXPR*PIX_W-1:0] src_data,
  output logic [PIX_W-1:0]        pix_data,
  output logic [ID_W-1:0]         cur_expr,
  output logic                    busy,
  output logic                    switch_pulse
);
  localparam int DW_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [DW_W-1:0] CNT_LAST = DW_W'(DWELL_FRAMES - 1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_EXPR - 1);
  localparam logic [ID_W-1:0] INIT_ID = ID_W'(INIT_EXPR);
  localparam logic [ID_W:0] N_LIM = (ID_W + 1)'(N_EXPR);

  function automatic logic [ID_W-1:0] nxt(input logic [ID_W-1:0] v);
    return (v == LAST_ID) ? '0 : v + 1'b1;
  endfunction

  logic            tick;
  logic            go_q;
  logic            rdy;
  logic            err_q;
  logic            sw_q;
  logic [ID_W-1:0] tgt;
  logic [DW_W-1:0] cnt;
  sel_state_t      st;

  logic            go_edge;
  logic            sel_acc;
  logic            sel_ok;
  logic            go_adv;
  logic            manual;
  logic            dwell_hit;
  logic            blank_on;

  frame_tick_gen #(
    .ADDR_W (ADDR_W)
  ) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_addr_x (pix_addr_x),
    .pix_addr_y (pix_addr_y),
    .tick       (tick)
  );

  assign go_edge   = go & ~go_q;
  assign sel_acc   = sel.sel_valid & rdy;
  assign sel_ok    = sel_acc & ({1'b0, sel.sel_id} < N_LIM);
  // An accepted select, valid or not, swallows a same-cycle go edge.
  assign go_adv    = go_edge & ~sel_acc;
  assign manual    = sel_acc | go_edge;
  assign dwell_hit = auto_en & tick & ~manual
                   & (tgt == cur_expr) & (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_q     <= 1'b1;
      rdy      <= 1'b0;
      err_q    <= 1'b0;
      sw_q     <= 1'b0;
      tgt      <= INIT_ID;
      cur_expr <= INIT_ID;
      cnt      <= '0;
      st       <= ST_SHOW;
    end else begin
      go_q  <= go;
      rdy   <= 1'b1;
      err_q <= sel_acc & ~sel_ok;
      sw_q  <= 1'b0;

      unique case (1'b1)
        sel_ok:    tgt <= sel.sel_id;
        go_adv:    tgt <= nxt(tgt);
        dwell_hit: tgt <= nxt(cur_expr);
        default:   ;
      endcase

      if (!auto_en || manual || sw_q)
        cnt <= '0;
      else if (tick && (tgt == cur_expr))
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

      unique case (st)
        ST_SHOW: begin
          if (tgt != cur_expr) st <= ST_PEND;
        end
        ST_PEND: begin
          if (tgt == cur_expr) begin
            st <= ST_SHOW;
          end else if (tick) begin
`ifdef EXPR_BLANK_EN
            st <= ST_BLANK;
`else
            cur_expr <= tgt;
            sw_q     <= 1'b1;
            st       <= ST_SHOW;
`endif
          end
        end
`ifdef EXPR_BLANK_EN
        ST_BLANK: begin
          if (tick) begin
            cur_expr <= tgt;
            sw_q     <= 1'b1;
            st       <= ST_SHOW;
          end
        end
`endif
        default: st <= ST_SHOW;
      endcase
    end
  end

`ifdef EXPR_BLANK_EN
  assign blank_on = (st == ST_BLANK);
`else
  assign blank_on = 1'b0;
`endif

  logic [PIX_W-1:0] src [N_EXPR];

  for (genvar k = 0; k < N_EXPR; k++) begin : g_src
    assign src[k] = src_data[k*PIX_W +: PIX_W];
  end

  assign pix_data      = blank_on ? BLANK_COLOR : src[cur_expr];
  assign busy          = (st != ST_SHOW);
  assign switch_pulse  = sw_q;
  assign sel.sel_ready = rdy;
  assign sel.sel_err   = err_q;
endmodule

// File: tb/tb_expression_sequencer.sv
// tb_expression_sequencer: directed bench for expression_sequencer.
// Scans a 4x4 LCD frame (origin held 2 cycles) and checks switching.
module tb_expression_sequencer;
  import expr_pkg::*;

  localparam int N    = 5;
  localparam int PW   = 16;
  localparam int AW   = 8;
  localparam int DW   = 2;
  localparam int IDW  = 3;
  localparam int COLS = 4;
  localparam int ROWS = 4;
  localparam int XS   = 20;
  localparam int YS   = 40;
  localparam int FL   = COLS * ROWS + 1;
`ifdef EXPR_BLANK_EN
  localparam int SWF = 2;
  localparam bit BLK = 1'b1;
`else
  localparam int SWF = 1;
  localparam bit BLK = 1'b0;
`endif
  // Tick that expires the dwell sets the target; a later tick switches.
  localparam int AUTO_P = DW + SWF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              go;
  logic              auto_en;
  logic [AW-1:0]     x;
  logic [AW-1:0]     y;
  logic [N*PW-1:0]   src_data;
  logic [PW-1:0]     pix_data;
  logic [IDW-1:0]    cur_expr;
  logic              busy;
  logic              switch_pulse;

  expression_sequencer_if #(.ID_W(IDW)) sel_if ();

  expression_sequencer #(
    .N_EXPR       (N),
    .PIX_W        (PW),
    .ADDR_W       (AW),
    .DWELL_FRAMES (DW),
    .INIT_EXPR    (0),
    .BLANK_COLOR  (16'h0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .go           (go),
    .auto_en      (auto_en),
    .sel          (sel_if),
    .pix_addr_x   (x),
    .pix_addr_y   (y),
    .src_data     (src_data),
    .pix_data     (pix_data),
    .cur_expr     (cur_expr),
    .busy         (busy),
    .switch_pulse (switch_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int sw_seen = 0;
  int err_seen = 0;

  logic [PW-1:0] pix_log [FL];
  int f_pulses;
  int f_pulse_p;
  int f_blank;
  int f_busy_low;

  function automatic logic [PW-1:0] src(input int k);
    return 16'(16'h1111 * (k + 1));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (switch_pulse) sw_seen++;
    if (sel_if.sel_err) err_seen++;
  endtask

  task automatic run_frame(input int go_at);
    f_pulses = 0;
    f_pulse_p = -1;
    f_blank = 0;
    f_busy_low = 0;
    for (int p = 0; p < FL; p++) begin
      int idx;
      idx = (p < 2) ? 0 : p - 1;
      x = 8'((idx % COLS) * XS);
      y = 8'((idx / COLS) * YS);
      go = (p == go_at);
      pix_log[p] = pix_data;
      if (pix_data == 16'h0000) f_blank++;
      if (!busy) f_busy_low++;
      step();
      if (switch_pulse) begin
        f_pulses++;
        f_pulse_p = p;
      end
    end
    go = 1'b0;
  endtask

  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) run_frame(-1);
  endtask

  task automatic req_go();
    go = 1'b1;
    step();
    go = 1'b0;
    step();
  endtask

  task automatic req_sel(input logic [IDW-1:0] id);
    sel_if.sel_valid = 1'b1;
    sel_if.sel_id = id;
    step();
    sel_if.sel_valid = 1'b0;
    step();
  endtask

  task automatic do_reset(input logic go_lvl);
    rst_n = 1'b0;
    go = go_lvl;
    auto_en = 1'b0;
    sel_if.sel_valid = 1'b0;
    sel_if.sel_id = '0;
    x = 8'd60;
    y = 8'd120;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    go = 1'b0;
    auto_en = 1'b0;
    sel_if.sel_valid = 1'b0;
    sel_if.sel_id = '0;
    x = 8'd60;
    y = 8'd120;
    step();
    step();
    checks++;
    if (cur_expr !== 3'd0) begin
      failures++;
      $display("FAIL reset_cur got=%0d exp=0", cur_expr);
    end
    checks++;
    if (sel_if.sel_ready !== 1'b0 || sel_if.sel_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_sel got rdy=%b err=%b exp 0 0", sel_if.sel_ready, sel_if.sel_err);
    end
    checks++;
    if (busy !== 1'b0 || switch_pulse !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got busy=%b sw=%b exp 0 0", busy, switch_pulse);
    end
    checks++;
    if (pix_data !== src(0)) begin
      failures++;
      $display("FAIL reset_pix got=%h exp=%h", pix_data, src(0));
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (sel_if.sel_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got=%b exp=1", sel_if.sel_ready);
    end
  endtask

  task automatic test_go_held();
    int s0;
    do_reset(1'b1);
    s0 = sw_seen;
    run_frames(2);
    checks++;
    if (cur_expr !== 3'd0 || sw_seen != s0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL go_held got cur=%0d sw=%0d busy=%b exp 0 0 0", cur_expr, sw_seen - s0, busy);
    end
  endtask

  task automatic test_go_wrap();
    int exp_c;
    exp_c = 0;
    for (int i = 0; i < 5; i++) begin
      int s0;
      exp_c = (exp_c + 1) % N;
      req_go();
      s0 = sw_seen;
      run_frames(SWF);
      checks++;
      if (cur_expr !== 3'(exp_c)) begin
        failures++;
        $display("FAIL go_wrap_cur step=%0d got=%0d exp=%0d", i, cur_expr, exp_c);
      end
      checks++;
      if (sw_seen - s0 != 1 || f_pulse_p != 0) begin
        failures++;
        $display("FAIL go_wrap_pulse step=%0d got n=%0d at=%0d exp 1 at 0", i, sw_seen - s0, f_pulse_p);
      end
    end
  endtask

  task automatic test_no_tear();
    int s0;
    s0 = sw_seen;
    run_frame(11);
    checks++;
    if (cur_expr !== 3'd0 || busy !== 1'b1 || sw_seen != s0) begin
      failures++;
      $display("FAIL tear_hold got cur=%0d busy=%b sw=%0d exp 0 1 0", cur_expr, busy, sw_seen - s0);
    end
    run_frames(SWF);
    checks++;
    if (cur_expr !== 3'd1 || f_pulse_p != 0) begin
      failures++;
      $display("FAIL tear_switch got cur=%0d at=%0d exp 1 at 0", cur_expr, f_pulse_p);
    end
    checks++;
    if (pix_log[0] !== (BLK ? 16'h0000 : src(0))) begin
      failures++;
      $display("FAIL tear_pix0 got=%h exp=%h", pix_log[0], BLK ? 16'h0000 : src(0));
    end
    checks++;
    if (pix_log[1] !== src(1) || pix_log[FL-1] !== src(1)) begin
      failures++;
      $display("FAIL tear_pix1 got=%h/%h exp=%h", pix_log[1], pix_log[FL-1], src(1));
    end
  endtask

  task automatic test_direct_select();
    int s0;
    int e0;
    req_sel(3'd3);
    s0 = sw_seen;
    run_frames(SWF);
    checks++;
    if (cur_expr !== 3'd3 || sw_seen - s0 != 1) begin
      failures++;
      $display("FAIL sel3 got cur=%0d sw=%0d exp 3 1", cur_expr, sw_seen - s0);
    end
    e0 = err_seen;
    sel_if.sel_valid = 1'b1;
    sel_if.sel_id = 3'd7;
    step();
    checks++;
    if (sel_if.sel_err !== 1'b1) begin
      failures++;
      $display("FAIL sel_err_pulse got=%b exp=1", sel_if.sel_err);
    end
    sel_if.sel_valid = 1'b0;
    step();
    checks++;
    if (sel_if.sel_err !== 1'b0) begin
      failures++;
      $display("FAIL sel_err_clear got=%b exp=0", sel_if.sel_err);
    end
    run_frame(-1);
    checks++;
    if (cur_expr !== 3'd3 || busy !== 1'b0 || err_seen - e0 != 1) begin
      failures++;
      $display("FAIL sel7 got cur=%0d busy=%b errs=%0d exp 3 0 1", cur_expr, busy, err_seen - e0);
    end
    go = 1'b1;
    sel_if.sel_valid = 1'b1;
    sel_if.sel_id = 3'd1;
    step();
    go = 1'b0;
    sel_if.sel_valid = 1'b0;
    step();
    run_frames(SWF);
    checks++;
    if (cur_expr !== 3'd1) begin
      failures++;
      $display("FAIL sel_beats_go got=%0d exp=1", cur_expr);
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    req_go();
    req_go();
    req_go();
    s0 = sw_seen;
    run_frames(SWF);
    checks++;
    if (cur_expr !== 3'd4 || sw_seen - s0 != 1) begin
      failures++;
      $display("FAIL accum got cur=%0d sw=%0d exp 4 1", cur_expr, sw_seen - s0);
    end
    s0 = sw_seen;
    run_frame(0);
    checks++;
    if (cur_expr !== 3'd4 || busy !== 1'b1 || sw_seen != s0) begin
      failures++;
      $display("FAIL tick_collide_hold got cur=%0d busy=%b sw=%0d exp 4 1 0", cur_expr, busy, sw_seen - s0);
    end
    run_frames(SWF);
    checks++;
    if (cur_expr !== 3'd0) begin
      failures++;
      $display("FAIL tick_collide_next got=%0d exp=0", cur_expr);
    end
  endtask

  task automatic test_pend_cancel();
    int s0;
    s0 = sw_seen;
    req_sel(3'd2);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL cancel_busy got=%b exp=1", busy);
    end
    req_sel(3'd0);
    run_frame(-1);
    checks++;
    if (busy !== 1'b0 || cur_expr !== 3'd0 || sw_seen != s0) begin
      failures++;
      $display("FAIL cancel got busy=%b cur=%0d sw=%0d exp 0 0 0", busy, cur_expr, sw_seen - s0);
    end
  endtask

  task automatic test_auto();
    auto_en = 1'b1;
    run_frames(AUTO_P - 1);
    checks++;
    if (cur_expr !== 3'd0) begin
      failures++;
      $display("FAIL auto_early got=%0d exp=0", cur_expr);
    end
    run_frame(-1);
    checks++;
    if (cur_expr !== 3'd1 || f_pulse_p != 0) begin
      failures++;
      $display("FAIL auto_first got cur=%0d at=%0d exp 1 at 0", cur_expr, f_pulse_p);
    end
    run_frames(AUTO_P);
    checks++;
    if (cur_expr !== 3'd2) begin
      failures++;
      $display("FAIL auto_second got=%0d exp=2", cur_expr);
    end
    run_frame(-1);
    req_go();
    run_frames(SWF);
    checks++;
    if (cur_expr !== 3'd3) begin
      failures++;
      $display("FAIL auto_go got=%0d exp=3", cur_expr);
    end
    run_frames(AUTO_P - 1);
    checks++;
    if (cur_expr !== 3'd3) begin
      failures++;
      $display("FAIL auto_restart_hold got=%0d exp=3", cur_expr);
    end
    run_frame(-1);
    checks++;
    if (cur_expr !== 3'd4) begin
      failures++;
      $display("FAIL auto_restart_adv got=%0d exp=4", cur_expr);
    end
    auto_en = 1'b0;
    step();
  endtask

  task automatic test_blank();
    int a_blank;
    int a_busy_low;
    int a_pulses;
    logic [PW-1:0] a_p0;
    req_sel(3'd0);
    run_frames(SWF);
    req_sel(3'd2);
    run_frame(-1);
    a_blank = f_blank;
    a_busy_low = f_busy_low;
    a_pulses = f_pulses;
    a_p0 = pix_log[0];
    run_frame(-1);
    checks++;
    if (a_p0 !== src(0) || a_pulses != (BLK ? 0 : 1)) begin
      failures++;
      $display("FAIL blank_first got pix=%h pulses=%0d exp %h %0d", a_p0, a_pulses, src(0), BLK ? 0 : 1);
    end
    checks++;
    if (a_blank + f_blank != (BLK ? FL : 0)) begin
      failures++;
      $display("FAIL blank_count got=%0d exp=%0d", a_blank + f_blank, BLK ? FL : 0);
    end
    checks++;
    if (a_busy_low != (BLK ? 0 : FL - 1)) begin
      failures++;
      $display("FAIL blank_busy got=%0d exp=%0d", a_busy_low, BLK ? 0 : FL - 1);
    end
    checks++;
    if (pix_log[1] !== src(2) || cur_expr !== 3'd2) begin
      failures++;
      $display("FAIL blank_after got pix=%h cur=%0d exp %h 2", pix_log[1], cur_expr, src(2));
    end
  endtask

  task automatic test_reset_mid_pend();
    int s0;
    req_sel(3'd4);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pend got=%b exp=1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (cur_expr !== 3'd0 || busy !== 1'b0 || pix_data !== src(0)) begin
      failures++;
      $display("FAIL midrst_async got cur=%0d busy=%b pix=%h exp 0 0 %h", cur_expr, busy, pix_data, src(0));
    end
    checks++;
    if (sel_if.sel_ready !== 1'b0 || switch_pulse !== 1'b0 || sel_if.sel_err !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outs got rdy=%b sw=%b err=%b exp 0 0 0", sel_if.sel_ready, switch_pulse, sel_if.sel_err);
    end
    step();
    rst_n = 1'b1;
    step();
    s0 = sw_seen;
    run_frames(2 * SWF);
    checks++;
    if (sw_seen != s0 || cur_expr !== 3'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_after got sw=%0d cur=%0d busy=%b exp 0 0 0", sw_seen - s0, cur_expr, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) src_data[k*PW +: PW] = src(k);
    test_reset();
    test_go_held();
    test_go_wrap();
    test_no_tear();
    test_direct_select();
    test_back_to_back();
    test_pend_cancel();
    test_auto();
    test_blank();
    test_reset_mid_pend();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
